// File: rtl/seq_mag_cmp_pkg.sv
// Shared types for the sequential magnitude comparator: FSM states and
// the one-hot result encoding (bit0 = eq, bit1 = gt, bit2 = lt).
package seq_mag_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] RES_NONE = 3'b000;
    localparam logic [2:0] RES_EQ   = 3'b001;
    localparam logic [2:0] RES_GT   = 3'b010;
    localparam logic [2:0] RES_LT   = 3'b100;

endpackage

// File: rtl/seq_mag_comparator_chunk_cmp.sv
// Combinational compare of one DIGIT-bit chunk, including the two's-complement
// sign rule that only applies to the most significant chunk.
module chunk_cmp
    import seq_mag_cmp_pkg::*;
#(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             msb_chunk,
    input  logic             is_signed,
    output logic             differ,
    output logic             x_greater
);

    logic sign_split;

    always_comb begin
        // Differing sign bits decide a signed compare outright; with equal
        // sign bits the plain unsigned chunk compare is correct.
        sign_split = is_signed && msb_chunk && (x[DIGIT-1] != y[DIGIT-1]);
        differ     = sign_split || (x != y);
        x_greater  = sign_split ? ~x[DIGIT-1] : (x > y);
    end

endmodule

// File: rtl/seq_mag_comparator.sv
// Multi-cycle magnitude comparator: scans DIGIT-bit chunks MSB first and stops
// at the first difference. Optional max/min outputs: SEQ_MAG_CMP_MINMAX_EN.
module seq_mag_comparator
    import seq_mag_cmp_pkg::*;
#(
    parameter  int WIDTH  = 16,
    parameter  int DIGIT  = 4,
    localparam int NCHUNK = WIDTH / DIGIT,
    localparam int CW     = $clog2(NCHUNK + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             eq,
    output logic             gt,
    output logic             lt,
    output logic [CW-1:0]    cycles
`ifdef SEQ_MAG_CMP_MINMAX_EN
    ,
    output logic [WIDTH-1:0] max_out,
    output logic [WIDTH-1:0] min_out
`endif
);

    localparam int IDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] idx_reg;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic             signed_reg;
    logic [2:0]       res_reg, res_next;
    logic [CW-1:0]    cycles_reg;
    logic [DIGIT-1:0] a_chunk [NCHUNK];
    logic [DIGIT-1:0] b_chunk [NCHUNK];
    logic             differ, x_greater, last_chunk, accept, decide;

    generate
        for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunks
            assign a_chunk[gi] = a_reg[gi*DIGIT +: DIGIT];
            assign b_chunk[gi] = b_reg[gi*DIGIT +: DIGIT];
        end
    endgenerate

    chunk_cmp #(.DIGIT(DIGIT)) u_chunk_cmp (
        .x         (a_chunk[idx_reg]),
        .y         (b_chunk[idx_reg]),
        .msb_chunk (idx_reg == IDX_W'(NCHUNK - 1)),
        .is_signed (signed_reg),
        .differ    (differ),
        .x_greater (x_greater)
    );

    assign last_chunk = (idx_reg == '0);
    assign accept     = (state_reg == IDLE) && in_valid;
    assign decide     = (state_reg == SCAN) && (differ || last_chunk);

    always_comb begin
        state_next = state_reg;
        res_next   = differ ? (x_greater ? RES_GT : RES_LT) : RES_EQ;
        case (state_reg)
            IDLE:    if (in_valid)  state_next = SCAN;
            SCAN:    if (decide)    state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            idx_reg    <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            signed_reg <= 1'b0;
            res_reg    <= RES_NONE;
            cycles_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                a_reg      <= a;
                b_reg      <= b;
                signed_reg <= is_signed;
                idx_reg    <= IDX_W'(NCHUNK - 1);
            end else if (state_reg == SCAN) begin
                if (decide) begin
                    res_reg    <= res_next;
                    cycles_reg <= CW'(NCHUNK) - CW'(idx_reg);
                end else begin
                    idx_reg <= idx_reg - IDX_W'(1);
                end
            end else if ((state_reg == DONE) && out_ready) begin
                // Flags must read zero whenever no result is on offer.
                res_reg <= RES_NONE;
            end
        end
    end

`ifdef SEQ_MAG_CMP_MINMAX_EN
    logic [WIDTH-1:0] max_reg, min_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_reg <= '0;
            min_reg <= '0;
        end else if (decide) begin
            // Equal operands leave both outputs equal to a.
            max_reg <= (res_next == RES_LT) ? b_reg : a_reg;
            min_reg <= (res_next == RES_GT) ? b_reg : a_reg;
        end
    end

    assign max_out = max_reg;
    assign min_out = min_reg;
`endif

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign eq        = res_reg[0];
    assign gt        = res_reg[1];
    assign lt        = res_reg[2];
    assign cycles    = cycles_reg;

endmodule
